fft_input_reorder: RTL and testbench
====================================

# fft_input_reorder

Input stage of the 32-point DIT FFT. It captures one frame of 32 complex samples arriving in natural order over a valid/ready stream. It then emits the frame as 16 bit-reversed butterfly operand pairs, one pair per handshake, on ports that map directly onto the first-stage `MAC_unit` `in_1_*`/`in_2_*` inputs. First-stage twiddles are all W^0, so this block carries no twiddle data.

## Interface
Parameters:
- `WIDTH`, 8, signed two's-complement width of each real/imag component (same fixed-point format as the butterfly).
- `N`, 32, points per frame; fixed at 32 for this design, and `LOG2N` = 5 is derived from it.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  block can accept a sample.
- `s_real`  in  WIDTH  input sample, real part, signed.
- `s_imag`  in  WIDTH  input sample, imaginary part, signed.
- `s_last`  in  1  marks the final sample of a frame.
- `m_valid`  out  1  operand pair valid.
- `m_ready`  in  1  downstream accepts the pair.
- `out_1_real`, `out_1_imag`  out  WIDTH each  even operand x[bitrev(2k)].
- `out_2_real`, `out_2_imag`  out  WIDTH each  odd operand x[bitrev(2k+1)], which equals x[bitrev(2k)+16].
- `pair_idx`  out  4  pair index k, 0..15.
- `m_last`  out  1  high with pair 15.
- `frame_err`  out  1  one-cycle error pulse; present only with `FFT_INBUF_FRAME_CHECK_EN`.

## Operation
State machine with two states, FILL and DRAIN. Reset enters FILL.

FILL:
- `s_ready` = 1; `m_valid` = 0.
- On each `s_valid & s_ready`, store the sample at index `wr_cnt` (natural order), then increment `wr_cnt`.
- When sample 31 is accepted: go to DRAIN, clear `wr_cnt`, clear `k`.

DRAIN:
- `s_ready` = 0; `m_valid` = 1.
- Outputs select storage entries bitrev5(2k) and bitrev5(2k)+16. Selection is combinational from the storage registers.
- On `m_valid & m_ready`: if k < 15, increment k; if k = 15, go to FILL.

Data and output rules:
- No arithmetic is performed. Data passes bit-exact; no scaling or saturation.
- When `m_valid` = 0, `out_*`, `pair_idx` and `m_last` are driven to 0.
- While `m_valid & !m_ready`, all `out_*`, `pair_idx` and `m_last` hold stable.
- Storage is not cleared between frames. Every entry is overwritten before it is next read.

Reset:
- Asserting reset mid-FILL or mid-DRAIN discards the frame.
- Reset state: FILL, `wr_cnt` = 0, `k` = 0, `m_valid` = 0, `s_ready` = 1, all data outputs 0, `frame_err` = 0. Storage contents after reset are don't-care.

## Timing
- Input throughput: 1 sample per cycle. A full frame takes 32 accepting cycles.
- Fill-to-output latency: the first pair is valid in the cycle immediately after the edge that accepts sample 31.
- Drain throughput: 1 pair per cycle with `m_ready` held high, so 16 cycles per frame.
- Return to input: `s_ready` rises in the cycle after pair 15 is accepted.
- No overlap: a frame cannot be captured while the previous one drains. Sustained rate is 48 cycles per frame minimum.
- `s_ready` and `m_valid` are decoded from the registered state only. Neither has a combinational path from `s_valid` or `m_ready`.

## Configuration
`FFT_INBUF_FRAME_CHECK_EN`

Defined:
- `s_last` is checked on every accepted sample.
- `s_last` on sample index < 31: pulse `frame_err` for one cycle, reset `wr_cnt` to 0, stay in FILL. The partial frame is discarded and that sample is not kept.
- `s_last` = 0 on sample 31: pulse `frame_err` for one cycle; the frame is still drained normally.

Undefined:
- `s_last` is ignored and the `frame_err` port does not exist.
- Frame boundaries are set purely by `wr_cnt`.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N` = 32 and `FFT_LOG2N` = 5;
  - the FILL/DRAIN state enum;
  - function `bitrev5`.
- Optional sub-module `bit_reverse` (parameter `BITS`): a purely combinational index reversal, reusable by later stage sequencers.
- Storage is a 32-entry register array of {real, imag}.

## Test plan
1. **Reset values.** Assert `rst_n` = 0 mid-DRAIN → next cycle `s_ready` = 1, `m_valid` = 0, all outputs 0. Then feed a fresh frame → correct order.
2. **Order check.** Feed 32 samples back-to-back with x[i] = (i, −i) and hold `m_ready` = 1 → expected pairs:
   - k=0: (0, 0)/(16, −16); k=1: (8, −8)/(24, −24); k=2: (4, −4)/(20, −20);
   - k=3: (12, −12)/(28, −28); k=15: (15, −15)/(31, −31).
   - `m_last` is high only at k=15; the first pair appears 1 cycle after sample 31.
3. **Backpressure.** Hold `m_ready` = 0 for 5 cycles at k=7 → outputs and `pair_idx` = 7 stable throughout. Release → k=8 follows the next cycle.
4. **Input gaps.** Toggle `s_valid` randomly (about 50%) → same 16 pairs as scenario 2. `s_ready` stays 0 for the whole of DRAIN.
5. **Extremes.** Samples at −128 and +127 (WIDTH = 8) → passed bit-exact, with no sign corruption.
6. **Frame check (macro defined).**
   - `s_last` on sample 10 → `frame_err` pulses once and the next 32 samples form the frame.
   - Missing `s_last` on sample 31 → `frame_err` pulses and the frame is still drained.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point DIT FFT: frame size, the input buffer
// FILL/DRAIN state encoding, and the 5-bit index bit reversal.
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } inbuf_state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = idx[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational index bit reversal, reusable by any FFT stage sequencer.
module bit_reverse #(
  parameter int BITS = 5
) (
  input  logic [BITS-1:0] idx,
  output logic [BITS-1:0] rev
);

  for (genvar gi = 0; gi < BITS; gi++) begin : g_rev
    assign rev[gi] = idx[BITS-1-gi];
  end

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input stage: captures 32 natural-order samples, then drains them as 16
// bit-reversed butterfly operand pairs. Optional s_last checking: FFT_INBUF_FRAME_CHECK_EN.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_real,
  input  logic [WIDTH-1:0] s_imag,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] out_1_real,
  output logic [WIDTH-1:0] out_1_imag,
  output logic [WIDTH-1:0] out_2_real,
  output logic [WIDTH-1:0] out_2_imag,
  output logic [3:0]       pair_idx,
  output logic             m_last
`ifdef FFT_INBUF_FRAME_CHECK_EN
  ,
  output logic             frame_err
`endif
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST_SAMPLE = LOG2N'(N - 1);
  localparam logic [3:0]       LAST_PAIR   = 4'(N / 2 - 1);

  inbuf_state_t     state_reg, state_next;
  logic [LOG2N-1:0] wr_cnt_reg, wr_cnt_next;
  logic [3:0]       k_reg, k_next;
  logic             err_reg, err_next;
  logic             wr_en;

  logic [2*WIDTH-1:0] mem [N];
  logic [LOG2N-1:0]   rd_idx_1, rd_idx_2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_FILL;
      wr_cnt_reg <= '0;
      k_reg      <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      k_reg      <= k_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    k_next      = k_reg;
    err_next    = 1'b0;
    wr_en       = 1'b0;
    case (state_reg)
      ST_FILL: begin
        if (s_valid) begin
          wr_en       = 1'b1;
          wr_cnt_next = wr_cnt_reg + 1'b1;
          if (wr_cnt_reg == LAST_SAMPLE) begin
            state_next  = ST_DRAIN;
            wr_cnt_next = '0;
            k_next      = '0;
          end
`ifdef FFT_INBUF_FRAME_CHECK_EN
          // Early s_last drops the partial frame and the offending sample;
          // a missing s_last on the final sample is only flagged.
          if (s_last && (wr_cnt_reg != LAST_SAMPLE)) begin
            wr_en       = 1'b0;
            wr_cnt_next = '0;
            err_next    = 1'b1;
          end
          if (!s_last && (wr_cnt_reg == LAST_SAMPLE)) begin
            err_next = 1'b1;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (k_reg == LAST_PAIR) begin
            state_next = ST_FILL;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Storage has no reset; every entry is rewritten before it is read again.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt_reg] <= {s_real, s_imag};
    end
  end

  // bitrev(2k) always lands in the lower half; its partner bitrev(2k+1) is +16.
  bit_reverse #(.BITS(LOG2N)) u_bit_reverse (
    .idx ({k_reg, 1'b0}),
    .rev (rd_idx_1)
  );
  assign rd_idx_2 = bitrev5({k_reg, 1'b1});

  assign s_ready = (state_reg == ST_FILL);
  assign m_valid = (state_reg == ST_DRAIN);

  assign out_1_real = m_valid ? mem[rd_idx_1][2*WIDTH-1:WIDTH] : '0;
  assign out_1_imag = m_valid ? mem[rd_idx_1][WIDTH-1:0]       : '0;
  assign out_2_real = m_valid ? mem[rd_idx_2][2*WIDTH-1:WIDTH] : '0;
  assign out_2_imag = m_valid ? mem[rd_idx_2][WIDTH-1:0]       : '0;
  assign pair_idx   = m_valid ? k_reg : 4'd0;
  assign m_last     = m_valid && (k_reg == LAST_PAIR);

`ifdef FFT_INBUF_FRAME_CHECK_EN
  assign frame_err = err_reg;
`else
  logic unused_frame_inputs;
  assign unused_frame_inputs = s_last ^ err_reg;
`endif

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: random frames against a reference
// reorder model, with gaps, backpressure, reset and optional frame checks.
module tb_fft_input_reorder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_real;
  logic [WIDTH-1:0] s_imag;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] out_1_real, out_1_imag, out_2_real, out_2_imag;
  logic [3:0]       pair_idx;
  logic             m_last;
`ifdef FFT_INBUF_FRAME_CHECK_EN
  logic             frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] fr_re [32];
  logic [WIDTH-1:0] fr_im [32];
  logic [WIDTH-1:0] obs_1_re [16];
  logic [WIDTH-1:0] obs_2_re [16];

  fft_input_reorder #(.WIDTH(WIDTH), .N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_real     (s_real),
    .s_imag     (s_imag),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .out_1_real (out_1_real),
    .out_1_imag (out_1_imag),
    .out_2_real (out_2_real),
    .out_2_imag (out_2_imag),
    .pair_idx   (pair_idx),
    .m_last     (m_last)
`ifdef FFT_INBUF_FRAME_CHECK_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference bit reversal by repeated division: peel LSBs, push into result.
  function automatic int rev5(input int i);
    int r = 0;
    int v = i;
    for (int b = 0; b < 5; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic fill_random;
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = WIDTH'($urandom);
      fr_im[i] = WIDTH'($urandom);
    end
  endtask

  task automatic fill_ramp;
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = WIDTH'(i);
      fr_im[i] = WIDTH'(-i);
    end
  endtask

  function automatic bit outputs_zero();
    return (out_1_real == 0) && (out_1_imag == 0) && (out_2_real == 0) &&
           (out_2_imag == 0) && (pair_idx == 0) && (m_last == 0);
  endfunction

  // Feed the frame in fr_*; called and returns at #1 after a clock edge.
  task automatic feed(input int gap_pct, input bit omit_last, input string tag);
    int i = 0;
    int guard = 0;
    while (i < 32 && guard < 1000) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_real  = fr_re[i];
      s_imag  = fr_im[i];
      s_last  = (i == 31) && !omit_last;
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || !outputs_zero()) begin
        n_fail++;
        $display("FAIL %s fill_state: s_ready=%b m_valid=%b pair_idx=%0d, required 1/0/0", tag, s_ready, m_valid, pair_idx);
      end
      @(posedge clk); #1;
      if (s_valid) i++;
      guard++;
`ifdef FFT_INBUF_FRAME_CHECK_EN
      n_checks++;
      if (frame_err !== ((i == 32) && omit_last)) begin
        n_fail++;
        $display("FAIL %s frame_err: got %b required %b (sample %0d)", tag, frame_err, (i == 32) && omit_last, i);
      end
`endif
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if (i < 32) begin
      n_fail++;
      $display("FAIL %s feed_timeout: accepted %0d required 32", tag, i);
    end
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s fill_latency: m_valid=%b required 1 one cycle after sample 31", tag, m_valid);
    end
  endtask

  // Drain 16 pairs; optionally stall 5 cycles at pair stall_k.
  task automatic drain(input int stall_pct, input int stall_k, input string tag);
    int k = 0;
    int guard = 0;
    int stall = 0;
    while (k < 16 && guard < 2000) begin
      if (stall_k == k && stall < 5) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = ($urandom_range(99) >= stall_pct);
      end
      n_checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s drain_state: m_valid=%b s_ready=%b required 1/0", tag, m_valid, s_ready);
      end
      n_checks++;
      if (out_1_real !== fr_re[rev5(2*k)] || out_1_imag !== fr_im[rev5(2*k)] ||
          out_2_real !== fr_re[rev5(2*k+1)] || out_2_imag !== fr_im[rev5(2*k+1)] ||
          pair_idx !== 4'(k) || m_last !== (k == 15)) begin
        n_fail++;
        $display("FAIL %s pair: got k=%0d (%0d,%0d)/(%0d,%0d) last=%b required k=%0d (%0d,%0d)/(%0d,%0d) last=%b",
                 tag, pair_idx, $signed(out_1_real), $signed(out_1_imag), $signed(out_2_real), $signed(out_2_imag), m_last,
                 k, $signed(fr_re[rev5(2*k)]), $signed(fr_im[rev5(2*k)]),
                 $signed(fr_re[rev5(2*k+1)]), $signed(fr_im[rev5(2*k+1)]), k == 15);
      end
      obs_1_re[k] = out_1_real;
      obs_2_re[k] = out_2_real;
      if (m_ready)
        $display("%s pair k=%0d x1=(%0d,%0d) x2=(%0d,%0d) last=%b", tag, pair_idx,
                 $signed(out_1_real), $signed(out_1_imag), $signed(out_2_real), $signed(out_2_imag), m_last);
      @(posedge clk); #1;
      if (m_ready) k++;
      guard++;
    end
    m_ready = 1'b0;
    n_checks++;
    if (k < 16) begin
      n_fail++;
      $display("FAIL %s drain_timeout: pairs %0d required 16", tag, k);
    end
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || !outputs_zero()) begin
      n_fail++;
      $display("FAIL %s return_to_fill: s_ready=%b m_valid=%b required 1/0 with zero outputs", tag, s_ready, m_valid);
    end
  endtask

  task automatic test_reset;
    fill_random();
    feed(0, 1'b0, "reset_pre");
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || !outputs_zero()) begin
      n_fail++;
      $display("FAIL reset_mid_drain: s_ready=%b m_valid=%b pair_idx=%0d required 1/0/0", s_ready, m_valid, pair_idx);
    end
    m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset asserted mid-drain, fresh frame follows");
    fill_random();
    feed(0, 1'b0, "reset_post");
    drain(0, -1, "reset_post");
  endtask

  task automatic test_order;
    fill_ramp();
    feed(0, 1'b0, "order");
    drain(0, -1, "order");
    n_checks++;
    if (obs_1_re[1] !== 8'd8 || obs_2_re[1] !== 8'd24 || obs_1_re[3] !== 8'd12 || obs_2_re[15] !== 8'd31) begin
      n_fail++;
      $display("FAIL order_literal: got k1=%0d/%0d k3=%0d k15b=%0d required 8/24/12/31",
               obs_1_re[1], obs_2_re[1], obs_1_re[3], obs_2_re[15]);
    end
  endtask

  task automatic test_backpressure;
    fill_random();
    feed(0, 1'b0, "backpressure");
    drain(0, 7, "backpressure");
  endtask

  task automatic test_input_gaps;
    for (int f = 0; f < 3; f++) begin
      fill_ramp();
      feed(50, 1'b0, "gaps");
      drain(30, -1, "gaps");
    end
  endtask

  task automatic test_extremes;
    for (int i = 0; i < 32; i++) begin
      fr_re[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
      fr_im[i] = (i % 3 == 0) ? 8'h7F : ((i % 3 == 1) ? 8'h80 : 8'hFF);
    end
    feed(0, 1'b0, "extremes");
    drain(0, -1, "extremes");
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      feed(20, 1'b0, "random");
      drain(25, -1, "random");
    end
  endtask

`ifdef FFT_INBUF_FRAME_CHECK_EN
  task automatic test_frame_check;
    int pulses = 0;
    for (int i = 0; i < 11; i++) begin
      s_valid = 1'b1;
      s_real  = 8'h55;
      s_imag  = 8'hAA;
      s_last  = (i == 10);
      @(posedge clk); #1;
      if (frame_err) pulses++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); #1;
    if (frame_err) pulses++;
    n_checks++;
    if (pulses != 1 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_last: pulses=%0d s_ready=%b m_valid=%b required 1/1/0", pulses, s_ready, m_valid);
    end
    $display("early s_last on sample 10, frame_err pulses=%0d", pulses);
    fill_random();
    feed(0, 1'b0, "after_early_last");
    drain(0, -1, "after_early_last");
    fill_random();
    feed(0, 1'b1, "missing_last");
    drain(0, -1, "missing_last");
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || !outputs_zero()) begin
      n_fail++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b pair_idx=%0d required 1/0/0", s_ready, m_valid, pair_idx);
    end
`ifdef FFT_INBUF_FRAME_CHECK_EN
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frame_err: got %b required 0", frame_err);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_order();
    test_backpressure();
    test_input_gaps();
    test_extremes();
    test_reset();
    test_back_to_back();
`ifdef FFT_INBUF_FRAME_CHECK_EN
    test_frame_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
